// File: rtl/regfile_wr_arbiter.sv
// Arbiter for the single register-file write port shared by the ALU path (req0) and the
// multi-cycle unit (req1). It uses round-robin arbitration with short, bounded locked bursts.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned      CntW   = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0]  MaxCnt = CntW'(MAX_LOCK);
  localparam bit               LockOn = (MAX_LOCK > 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              rr_q, rr_d;
  logic              gnt0, gnt1, own0, own1, pref, accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  logic              wr_en_q, wr_sel_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // The owner keeps the port only while it is still presenting a write.
  assign own0    = (state_q == StOwn0) && req0_valid;
  assign own1    = (state_q == StOwn1) && req1_valid;
  // A dropped owner hands preference to the other side in the same cycle.
  assign pref    = (state_q == StOwn0) ? 1'b1 : (state_q == StOwn1) ? 1'b0 : rr_q;
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (own0 || own1) begin
      gnt0 = own0;
      gnt1 = own1;
      if ((own0 ? req0_lock : req1_lock) && (cnt_inc < MaxCnt)) begin
        cnt_d = cnt_inc;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
        rr_d    = own0;
      end
    end else begin
      state_d = StIdle;
      cnt_d   = '0;
      rr_d    = pref;
      if (req0_valid && (!req1_valid || !pref)) begin
        gnt0 = 1'b1;
        rr_d = 1'b1;
        if (req0_lock && LockOn) begin
          state_d = StOwn0;
          cnt_d   = CntW'(1);
        end
      end else if (req1_valid) begin
        gnt1 = 1'b1;
        rr_d = 1'b0;
        if (req1_lock && LockOn) begin
          state_d = StOwn1;
          cnt_d   = CntW'(1);
        end
      end
    end
  end

  assign accept   = gnt0 | gnt1;
  assign acc_addr = gnt1 ? req1_addr : req0_addr;
  assign acc_data = gnt1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      // Writes to register 0 still complete the handshake but never reach the file.
      wr_en_q <= accept && (acc_addr != '0);
      if (accept) begin
        wr_sel_q  <= gnt1;
        wr_addr_q <= acc_addr;
        wr_data_q <= acc_data;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule
